// File: rtl/mem_request_arbiter.sv
// Round-robin arbiter that shares one memory controller (split rd/wr ports) between NREQ
// requesters; returned acks are steered back to their issuer through in-order tag FIFOs.

module mem_request_arbiter_tag_fifo #(
    parameter int W     = 2,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [W-1:0]             push_dat,
    input  logic                     pop,
    output logic [W-1:0]             head_dat,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Payload array needs no reset; pointers/count define validity.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_dat;
    end

    assign head_dat = mem[rd_ptr];
endmodule

module mem_request_arbiter #(
    parameter int NREQ  = 4,
    parameter int AW    = 16,
    parameter int DW    = 16,
    parameter int DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ-1:0]      req_write,
    input  logic [NREQ*AW-1:0]   req_address,
    input  logic [NREQ*DW-1:0]   req_data,
    output logic [NREQ-1:0]      req_ready,
    output logic [AW-1:0]        wr_address,
    output logic                 wr_en,
    output logic [DW-1:0]        wr_data,
    input  logic [AW-1:0]        wr_ret_address,
    input  logic                 wr_ret_ack,
    output logic [AW-1:0]        rd_address,
    output logic                 rd_en,
    input  logic [DW-1:0]        rd_ret_data,
    input  logic [AW-1:0]        rd_ret_address,
    input  logic                 rd_ret_ack,
    output logic [NREQ-1:0]      rd_resp_valid,
    output logic [AW-1:0]        rd_resp_address,
    output logic [DW-1:0]        rd_resp_data,
    output logic [NREQ-1:0]      wr_resp_valid,
    output logic [AW-1:0]        wr_resp_address,
    output logic                 err_spurious
);
    localparam int IW = $clog2(NREQ);
    localparam int CW = $clog2(DEPTH) + 1;

    // The RR pointers hold the next search start (last winner + 1), so after
    // reset requester 0 has first priority.
    logic [IW-1:0] rd_ptr, wr_ptr;
    logic [IW:0]   rd_pick, wr_pick;
    logic [IW-1:0] rd_win, wr_win;
    logic          rd_grant, wr_grant;
    logic [CW-1:0] rd_count, wr_count;
    logic [IW-1:0] rd_tag, wr_tag;
    logic          rd_pop, wr_pop;

    function automatic logic [IW:0] rr_pick(input logic [NREQ-1:0] cand,
                                            input logic [IW-1:0]   start);
        logic [IW:0] res;
        int          k;
        res = '0;
        // Walk backwards so the candidate closest to start overwrites the rest.
        for (int i = NREQ - 1; i >= 0; i--) begin
            k = (int'(start) + i) % NREQ;
            if (cand[k]) res = {1'b1, IW'(k)};
        end
        return res;
    endfunction

    function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] idx);
        return (int'(idx) == NREQ - 1) ? '0 : idx + IW'(1);
    endfunction

    assign rd_pick  = rr_pick(req_valid & ~req_write, rd_ptr);
    assign wr_pick  = rr_pick(req_valid &  req_write, wr_ptr);
    assign rd_win   = rd_pick[IW-1:0];
    assign wr_win   = wr_pick[IW-1:0];
    assign rd_grant = rst_n && rd_pick[IW] && (rd_count < CW'(DEPTH));
    assign wr_grant = rst_n && wr_pick[IW] && (wr_count < CW'(DEPTH));

    assign req_ready = (rd_grant ? (NREQ'(1) << rd_win) : '0)
                     | (wr_grant ? (NREQ'(1) << wr_win) : '0);

    assign rd_pop = rd_ret_ack && (rd_count != '0);
    assign wr_pop = wr_ret_ack && (wr_count != '0);

    mem_request_arbiter_tag_fifo #(.W(IW), .DEPTH(DEPTH)) u_rd_tags (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (rd_grant),
        .push_dat (rd_win),
        .pop      (rd_pop),
        .head_dat (rd_tag),
        .count    (rd_count)
    );

    mem_request_arbiter_tag_fifo #(.W(IW), .DEPTH(DEPTH)) u_wr_tags (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (wr_grant),
        .push_dat (wr_win),
        .pop      (wr_pop),
        .head_dat (wr_tag),
        .count    (wr_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr          <= '0;
            wr_ptr          <= '0;
            rd_en           <= 1'b0;
            wr_en           <= 1'b0;
            rd_address      <= '0;
            wr_address      <= '0;
            wr_data         <= '0;
            rd_resp_valid   <= '0;
            rd_resp_address <= '0;
            rd_resp_data    <= '0;
            wr_resp_valid   <= '0;
            wr_resp_address <= '0;
            err_spurious    <= 1'b0;
        end else begin
            rd_en <= rd_grant;
            wr_en <= wr_grant;
            if (rd_grant) begin
                rd_address <= req_address[rd_win*AW +: AW];
                rd_ptr     <= next_idx(rd_win);
            end
            if (wr_grant) begin
                wr_address <= req_address[wr_win*AW +: AW];
                wr_data    <= req_data[wr_win*DW +: DW];
                wr_ptr     <= next_idx(wr_win);
            end

            rd_resp_valid <= rd_pop ? (NREQ'(1) << rd_tag) : '0;
            if (rd_pop) begin
                rd_resp_address <= rd_ret_address;
                rd_resp_data    <= rd_ret_data;
            end
            wr_resp_valid <= wr_pop ? (NREQ'(1) << wr_tag) : '0;
            if (wr_pop) wr_resp_address <= wr_ret_address;

            if ((rd_ret_ack && !rd_pop) || (wr_ret_ack && !wr_pop))
                err_spurious <= 1'b1;
        end
    end
endmodule

// File: tb/tb_mem_request_arbiter.sv
// Directed bench for mem_request_arbiter: hand-computed grants, latencies, routing and errors.

module tb_mem_request_arbiter;
    localparam int NREQ = 4;
    localparam int AW   = 16;
    localparam int DW   = 16;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_write;
    logic [NREQ*AW-1:0]  req_address;
    logic [NREQ*DW-1:0]  req_data;
    logic [NREQ-1:0]     req_ready;
    logic [AW-1:0]       wr_address;
    logic                wr_en;
    logic [DW-1:0]       wr_data;
    logic [AW-1:0]       wr_ret_address;
    logic                wr_ret_ack;
    logic [AW-1:0]       rd_address;
    logic                rd_en;
    logic [DW-1:0]       rd_ret_data;
    logic [AW-1:0]       rd_ret_address;
    logic                rd_ret_ack;
    logic [NREQ-1:0]     rd_resp_valid;
    logic [AW-1:0]       rd_resp_address;
    logic [DW-1:0]       rd_resp_data;
    logic [NREQ-1:0]     wr_resp_valid;
    logic [AW-1:0]       wr_resp_address;
    logic                err_spurious;

    int n_cmp = 0;
    int n_err = 0;

    mem_request_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .DEPTH(4)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .req_valid       (req_valid),
        .req_write       (req_write),
        .req_address     (req_address),
        .req_data        (req_data),
        .req_ready       (req_ready),
        .wr_address      (wr_address),
        .wr_en           (wr_en),
        .wr_data         (wr_data),
        .wr_ret_address  (wr_ret_address),
        .wr_ret_ack      (wr_ret_ack),
        .rd_address      (rd_address),
        .rd_en           (rd_en),
        .rd_ret_data     (rd_ret_data),
        .rd_ret_address  (rd_ret_address),
        .rd_ret_ack      (rd_ret_ack),
        .rd_resp_valid   (rd_resp_valid),
        .rd_resp_address (rd_resp_address),
        .rd_resp_data    (rd_resp_data),
        .wr_resp_valid   (wr_resp_valid),
        .wr_resp_address (wr_resp_address),
        .err_spurious    (err_spurious)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n          = 1'b0;
        req_valid      = '0;
        req_write      = '0;
        req_address    = '0;
        req_data       = '0;
        wr_ret_address = '0;
        wr_ret_ack     = 1'b0;
        rd_ret_data    = '0;
        rd_ret_address = '0;
        rd_ret_ack     = 1'b0;
        #3;
        chk("rst_rd_en", 32'(rd_en), 0);
        chk("rst_wr_en", 32'(wr_en), 0);
        chk("rst_rd_resp_valid", 32'(rd_resp_valid), 0);
        chk("rst_err", 32'(err_spurious), 0);
        step();
        step();
        rst_n = 1'b1;

        // 1) single read from requester 1
        step();
        req_valid = 4'b0010;
        req_write = 4'b0000;
        req_address[1*AW +: AW] = 16'h0096;
        #1 chk("t1_ready", 32'(req_ready), 32'h2);
        step();
        req_valid = '0;
        chk("t1_rd_en", 32'(rd_en), 1);
        chk("t1_rd_address", 32'(rd_address), 32'h0096);
        rd_ret_ack     = 1'b1;
        rd_ret_data    = 16'h1234;
        rd_ret_address = 16'h0096;
        step();
        rd_ret_ack = 1'b0;
        chk("t1_rd_resp_valid", 32'(rd_resp_valid), 32'h2);
        chk("t1_rd_resp_data", 32'(rd_resp_data), 32'h1234);
        chk("t1_rd_resp_address", 32'(rd_resp_address), 32'h0096);
        chk("t1_rd_en_drop", 32'(rd_en), 0);
        step();
        chk("t1_rd_resp_pulse", 32'(rd_resp_valid), 0);

        // 2) four writers, acks returned every cycle once the first write is out
        for (int i = 0; i < NREQ; i++) begin
            req_address[i*AW +: AW] = AW'(16'h0100 + i);
            req_data[i*DW +: DW]    = DW'(16'hA000 + i);
        end
        req_valid = 4'b1111;
        req_write = 4'b1111;
        for (int k = 0; k < 6; k++) begin
            #1 chk($sformatf("t2_ready_%0d", k), 32'(req_ready), 32'(1 << (k % 4)));
            step();
            wr_ret_ack = 1'b1;
            chk($sformatf("t2_wr_en_%0d", k), 32'(wr_en), 1);
            chk($sformatf("t2_wr_data_%0d", k), 32'(wr_data), 32'(16'hA000 + (k % 4)));
            if (k > 0)
                chk($sformatf("t2_wr_resp_%0d", k), 32'(wr_resp_valid), 32'(1 << ((k - 1) % 4)));
        end
        req_valid = '0;
        req_write = '0;
        step();
        wr_ret_ack = 1'b0;
        chk("t2_wr_resp_last", 32'(wr_resp_valid), 32'h2);
        chk("t2_no_err", 32'(err_spurious), 0);

        // 3) simultaneous read (req2) and write (req3), then both acks together
        req_valid = 4'b1100;
        req_write = 4'b1000;
        req_address[2*AW +: AW] = 16'h0222;
        req_address[3*AW +: AW] = 16'h0333;
        req_data[3*DW +: DW]    = 16'hBEEF;
        #1 chk("t3_ready", 32'(req_ready), 32'hC);
        step();
        req_valid = '0;
        req_write = '0;
        chk("t3_rd_en", 32'(rd_en), 1);
        chk("t3_wr_en", 32'(wr_en), 1);
        chk("t3_rd_address", 32'(rd_address), 32'h0222);
        chk("t3_wr_address", 32'(wr_address), 32'h0333);
        chk("t3_wr_data", 32'(wr_data), 32'hBEEF);
        rd_ret_ack = 1'b1;
        wr_ret_ack = 1'b1;
        step();
        rd_ret_ack = 1'b0;
        wr_ret_ack = 1'b0;
        chk("t3_rd_resp", 32'(rd_resp_valid), 32'h4);
        chk("t3_wr_resp", 32'(wr_resp_valid), 32'h8);
        chk("t3_no_err", 32'(err_spurious), 0);

        // 5) read ack with an empty read FIFO
        rd_ret_ack = 1'b1;
        step();
        rd_ret_ack = 1'b0;
        chk("t5_no_resp", 32'(rd_resp_valid), 0);
        chk("t5_err", 32'(err_spurious), 1);
        step();
        step();
        chk("t5_err_held", 32'(err_spurious), 1);

        // 4) read FIFO fills at DEPTH, one ack frees a slot
        req_valid = 4'b0001;
        req_write = 4'b0000;
        req_address[0*AW +: AW] = 16'h0200;
        for (int k = 0; k < 4; k++) begin
            #1 chk($sformatf("t4_ready_%0d", k), 32'(req_ready), 32'h1);
            step();
            chk($sformatf("t4_rd_en_%0d", k), 32'(rd_en), 1);
        end
        #1 chk("t4_full_ready", 32'(req_ready), 0);
        step();
        chk("t4_full_rd_en", 32'(rd_en), 0);
        rd_ret_ack = 1'b1;
        #1 chk("t4_full_with_pop", 32'(req_ready), 0);
        step();
        rd_ret_ack = 1'b0;
        chk("t4_pop_resp", 32'(rd_resp_valid), 32'h1);
        chk("t4_still_blocked_en", 32'(rd_en), 0);
        #1 chk("t4_fifth_ready", 32'(req_ready), 32'h1);
        step();
        req_valid = '0;
        chk("t4_fifth_rd_en", 32'(rd_en), 1);
        chk("t4_fifth_address", 32'(rd_address), 32'h0200);
        rd_ret_ack = 1'b1;
        step();
        rd_ret_ack = 1'b0;
        chk("t4_second_pop", 32'(rd_resp_valid), 32'h1);

        // 6) reset with three reads outstanding
        req_valid = 4'b0001;
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rd_en", 32'(rd_en), 0);
        chk("t6_rd_resp_valid", 32'(rd_resp_valid), 0);
        chk("t6_rd_address", 32'(rd_address), 0);
        chk("t6_err", 32'(err_spurious), 0);
        chk("t6_ready", 32'(req_ready), 0);
        req_valid = '0;
        step();
        rst_n = 1'b1;
        rd_ret_ack = 1'b1;
        step();
        rd_ret_ack = 1'b0;
        chk("t6_late_no_resp", 32'(rd_resp_valid), 0);
        chk("t6_late_err", 32'(err_spurious), 1);
        req_valid = 4'b1111;
        req_write = 4'b0000;
        #1 chk("t6_regrant", 32'(req_ready), 32'h1);
        step();
        req_valid = '0;
        chk("t6_regrant_en", 32'(rd_en), 1);
        chk("t6_regrant_address", 32'(rd_address), 32'h0200);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
